pe_ctx_loop: RTL and testbench
==============================

// Module: pe_ctx_loop
// PURPOSE
//  Parametrised CGRA processing element: a context buffer of DEPTH instructions is loaded in init
//  mode, then sequenced in run mode with hardware looping (last-bit or loaded-length wrap).
//  Four neighbour links N/S/W/E (E now included), 4-entry local register file, registered ALU result.
//  Stall freezes all state. Tiles into the array wherever the fixed-width PE variants sit today.
// PARAMETERS
//  DW     32  datapath width (>=8)
//  DEPTH  16  context buffer entries (power of 2, >=2)
//  INST_W 24  localparam, fixed instruction width (layout below)
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous, active-high reset
//  init       in   1       load strobe: write cfg_inst at load pointer
//  cfg_inst   in   INST_W  context word to load
//  run        in   1       sequence contexts while high
//  stall      in   1       freeze pc, inst_r, res, rf, iter_cnt (run mode)
//  din_N/S/W/E in  DW      neighbour inputs
//  dout_N/S/W/E out DW     neighbour outputs (combinational from inst_r/res/rf)
//  cfg_full   out  1       load pointer == DEPTH
//  loop_done  out  1       1-cycle pulse when the last context is fetched
//  iter_cnt   out  16      completed loop iterations, wraps at 2^16
// BEHAVIOUR
//  Inst fields: [23:20] op, [19:17] srcA, [16:14] srcB, [13:6] out sel N,S,W,E (2b each, N at [13:12]),
//   [5] rf_we, [4:3] rd, [2:1] ra, [0] last.
//  Src enc: 0 N,1 S,2 W,3 E,4 res,5 rf[ra],6 const 0,7 const 1.
//  Out sel: 0 zero, 1 res, 2 opA (bypass), 3 rf[ra].
//  ALU ops: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SHL,6 SHR,7 SRA (shift by B[log2(DW)-1:0]),
//   8 MUL (low DW), 9 EQ,10 LTS (1/0), 11 MINS,12 MAXS,13 PASSA,14 PASSB,15 NOP. Wrap-around arith.
//  Reset: load_ptr=0, pc=0, inst_r=0, ex_valid=0, res=0, rf all 0, iter_cnt=0 -> all dout=0.
//  Init (priority over run): buf[load_ptr]<=cfg_inst, load_ptr++; write dropped when cfg_full.
//   A load also resets pc=0, ex_valid=0. Buffer not cleared by reloading; only rst.
//  Run (run & !stall & load_ptr!=0 & !init): inst_r<=buf[pc]; ex_valid<=1;
//   pc <= (buf[pc].last | pc==load_ptr-1) ? 0 : pc+1; that wrap asserts loop_done, iter_cnt++.
//  Run low (not stalled): ex_valid<=0, inst_r held (outputs keep last routing), pc held.
//  Execute: cycle after fetch, ALU reads inst_r; if ex_valid & op!=NOP: res<=alu; rf[rd]<=alu if rf_we.
//   Latency: fetch t -> res/rf visible t+2. Source res/rf reads pre-update value (no forwarding).
//  Stall: everything held incl. loop_done (forced 0); run+stall = pure hold.
//  rst mid-run: all state cleared next edge, buffer contents also zeroed.
// STRUCTURE
//  Package pe_ctx_pkg: INST_W, field offsets, opcode/src/out-sel localparams.
//  Sub-module pe_ctx_alu (comb, DW param, op/a/b -> y). Rest flat in pe_ctx_loop.
// TESTING
//  1 rst, load 1 ctx {ADD,N,W,out N=res,last}, din_N=5,din_W=7, run -> dout_N=12 at fetch+2, stays.
//  2 load 3 ctx no last bit, run 9 cycles -> pc 0,1,2,0..; loop_done every 3rd; iter_cnt=3.
//  3 ctx0 {ADD,res,const1,rf_we rd=2}, last set, run 10 -> res counts 1..10, rf[2]=res; out sel3 ra=2 matches.
//  4 stall 3 cycles mid-loop -> pc, res, dout, iter_cnt frozen; loop_done=0; resume continues sequence.
//  5 load DEPTH+2 words -> cfg_full=1, extra words dropped, wrap at DEPTH-1.
//  6 SRA 0x80000000 by 4 -> 0xF8000000; LTS(-1,1)=1; MUL 0xFFFF*0xFFFF -> 0xFFFE0001; rst mid-run -> dout=0.

Source files
------------

// File: rtl/pe_ctx_pkg.sv
// rtl/pe_ctx_pkg.sv - instruction layout, opcodes and selector encodings for the context-looping PE
package pe_ctx_pkg;

  localparam int INST_W = 24;

  localparam int OP_LSB     = 20;
  localparam int SRCA_LSB   = 17;
  localparam int SRCB_LSB   = 14;
  localparam int OSEL_N_LSB = 12;
  localparam int OSEL_S_LSB = 10;
  localparam int OSEL_W_LSB = 8;
  localparam int OSEL_E_LSB = 6;
  localparam int RF_WE_BIT  = 5;
  localparam int RD_LSB     = 3;
  localparam int RA_LSB     = 1;
  localparam int LAST_BIT   = 0;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SHL   = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_EQ    = 4'd9;
  localparam logic [3:0] OP_LTS   = 4'd10;
  localparam logic [3:0] OP_MINS  = 4'd11;
  localparam logic [3:0] OP_MAXS  = 4'd12;
  localparam logic [3:0] OP_PASSA = 4'd13;
  localparam logic [3:0] OP_PASSB = 4'd14;
  localparam logic [3:0] OP_NOP   = 4'd15;

  localparam logic [2:0] SRC_N    = 3'd0;
  localparam logic [2:0] SRC_S    = 3'd1;
  localparam logic [2:0] SRC_W    = 3'd2;
  localparam logic [2:0] SRC_E    = 3'd3;
  localparam logic [2:0] SRC_RES  = 3'd4;
  localparam logic [2:0] SRC_RF   = 3'd5;
  localparam logic [2:0] SRC_ZERO = 3'd6;
  localparam logic [2:0] SRC_ONE  = 3'd7;

  localparam logic [1:0] OSEL_ZERO = 2'd0;
  localparam logic [1:0] OSEL_RES  = 2'd1;
  localparam logic [1:0] OSEL_OPA  = 2'd2;
  localparam logic [1:0] OSEL_RF   = 2'd3;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic [1:0] osel_n;
    logic [1:0] osel_s;
    logic [1:0] osel_w;
    logic [1:0] osel_e;
    logic       rf_we;
    logic [1:0] rd;
    logic [1:0] ra;
    logic       last;
  } inst_t;

endpackage

// File: rtl/pe_ctx_alu.sv
// rtl/pe_ctx_alu.sv - combinational ALU of the PE, wrap-around arithmetic, shift amount from low bits of b
module pe_ctx_alu
  import pe_ctx_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [3:0]    op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] y_o
);

  localparam int SW = $clog2(DW);

  logic [SW-1:0] sh;
  logic          lts;

  assign sh  = b_i[SW-1:0];
  assign lts = $signed(a_i) < $signed(b_i);

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_ADD:   y_o = a_i + b_i;
      OP_SUB:   y_o = a_i - b_i;
      OP_AND:   y_o = a_i & b_i;
      OP_OR:    y_o = a_i | b_i;
      OP_XOR:   y_o = a_i ^ b_i;
      OP_SHL:   y_o = a_i << sh;
      OP_SHR:   y_o = a_i >> sh;
      OP_SRA:   y_o = $unsigned($signed(a_i) >>> sh);
      OP_MUL:   y_o = a_i * b_i;
      OP_EQ:    y_o = DW'(a_i == b_i);
      OP_LTS:   y_o = DW'(lts);
      OP_MINS:  y_o = lts ? a_i : b_i;
      OP_MAXS:  y_o = lts ? b_i : a_i;
      OP_PASSA: y_o = a_i;
      OP_PASSB: y_o = b_i;
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/pe_ctx_loop.sv
// rtl/pe_ctx_loop.sv - CGRA processing element with a loadable context buffer and hardware looping
module pe_ctx_loop
  import pe_ctx_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic [INST_W-1:0] cfg_inst,
  input  logic              run,
  input  logic              stall,
  input  logic [DW-1:0]     din_N,
  input  logic [DW-1:0]     din_S,
  input  logic [DW-1:0]     din_W,
  input  logic [DW-1:0]     din_E,
  output logic [DW-1:0]     dout_N,
  output logic [DW-1:0]     dout_S,
  output logic [DW-1:0]     dout_W,
  output logic [DW-1:0]     dout_E,
  output logic              cfg_full,
  output logic              loop_done,
  output logic [15:0]       iter_cnt
);

  localparam int PW = $clog2(DEPTH);

  inst_t         buf_q [DEPTH];
  logic [PW:0]   load_ptr_q, load_ptr_d;
  logic [PW-1:0] pc_q, pc_d;
  inst_t         inst_q, inst_d;
  logic          ex_valid_q, ex_valid_d;
  logic          loop_done_q, loop_done_d;
  logic [DW-1:0] res_q, res_d;
  logic [DW-1:0] rf_q [4];
  logic [DW-1:0] rf_d [4];
  logic [15:0]   iter_q, iter_d;

  inst_t         cur;
  logic [PW:0]   last_idx;
  logic          fetch_en, wrap;
  logic [DW-1:0] op_a, op_b, alu_y, rf_ra;

  function automatic logic [DW-1:0] src_mux(input logic [2:0] s, input logic [DW-1:0] n,
                                            input logic [DW-1:0] so, input logic [DW-1:0] w,
                                            input logic [DW-1:0] e, input logic [DW-1:0] r,
                                            input logic [DW-1:0] f);
    case (s)
      SRC_N:   return n;
      SRC_S:   return so;
      SRC_W:   return w;
      SRC_E:   return e;
      SRC_RES: return r;
      SRC_RF:  return f;
      SRC_ONE: return DW'(1);
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] out_mux(input logic [1:0] sel, input logic [DW-1:0] r,
                                            input logic [DW-1:0] a, input logic [DW-1:0] f);
    case (sel)
      OSEL_RES: return r;
      OSEL_OPA: return a;
      OSEL_RF:  return f;
      default:  return '0;
    endcase
  endfunction

  assign rf_ra = rf_q[inst_q.ra];
  assign op_a  = src_mux(inst_q.src_a, din_N, din_S, din_W, din_E, res_q, rf_ra);
  assign op_b  = src_mux(inst_q.src_b, din_N, din_S, din_W, din_E, res_q, rf_ra);

  pe_ctx_alu #(.DW(DW)) u_alu (
    .op_i (inst_q.op),
    .a_i  (op_a),
    .b_i  (op_b),
    .y_o  (alu_y)
  );

  // Routing follows the held instruction, so outputs persist while run is low.
  assign dout_N = out_mux(inst_q.osel_n, res_q, op_a, rf_ra);
  assign dout_S = out_mux(inst_q.osel_s, res_q, op_a, rf_ra);
  assign dout_W = out_mux(inst_q.osel_w, res_q, op_a, rf_ra);
  assign dout_E = out_mux(inst_q.osel_e, res_q, op_a, rf_ra);

  assign cfg_full  = (load_ptr_q == (PW+1)'(DEPTH));
  assign loop_done = loop_done_q;
  assign iter_cnt  = iter_q;

  assign cur      = buf_q[pc_q];
  assign last_idx = load_ptr_q - 1'b1;
  assign wrap     = cur.last | ({1'b0, pc_q} == last_idx);
  assign fetch_en = run & ~stall & ~init & (load_ptr_q != '0);

  always_comb begin
    load_ptr_d  = load_ptr_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    ex_valid_d  = ex_valid_q;
    loop_done_d = 1'b0;
    res_d       = res_q;
    rf_d        = rf_q;
    iter_d      = iter_q;

    // Execute stage uses the pre-update res/rf; no forwarding.
    if (!stall && ex_valid_q && inst_q.op != OP_NOP) begin
      res_d = alu_y;
      if (inst_q.rf_we) rf_d[inst_q.rd] = alu_y;
    end

    if (init) begin
      if (!cfg_full) load_ptr_d = load_ptr_q + 1'b1;
      pc_d       = '0;
      ex_valid_d = 1'b0;
    end else if (stall) begin
      loop_done_d = 1'b0;
    end else if (fetch_en) begin
      inst_d      = cur;
      ex_valid_d  = 1'b1;
      pc_d        = wrap ? '0 : pc_q + 1'b1;
      loop_done_d = wrap;
      iter_d      = iter_q + {15'd0, wrap};
    end else begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_ptr_q  <= '0;
      pc_q        <= '0;
      inst_q      <= '0;
      ex_valid_q  <= 1'b0;
      loop_done_q <= 1'b0;
      res_q       <= '0;
      iter_q      <= '0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      load_ptr_q  <= load_ptr_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      ex_valid_q  <= ex_valid_d;
      loop_done_q <= loop_done_d;
      res_q       <= res_d;
      iter_q      <= iter_d;
      for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
      if (init && !cfg_full) buf_q[load_ptr_q[PW-1:0]] <= cfg_inst;
    end
  end

endmodule

// File: tb/tb_pe_ctx_loop.sv
// tb/tb_pe_ctx_loop.sv - self-checking bench for pe_ctx_loop against a behavioural model
module tb_pe_ctx_loop;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0, init = 1'b0, run = 1'b0, stall = 1'b0;
  logic [23:0] cfg_inst = '0;
  logic [31:0] din_n = '0, din_s = '0, din_w = '0, din_e = '0;
  logic [31:0] dout_n, dout_s, dout_w, dout_e;
  logic        cfg_full, loop_done;
  logic [15:0] iter_cnt;

  int total = 0;
  int bad   = 0;
  int ld_seen = 0;

  logic [23:0] m_buf [DEPTH];
  int          m_lp, m_pc;
  logic [23:0] m_inst;
  bit          m_ev, m_ld;
  logic [31:0] m_res;
  logic [31:0] m_rf [4];
  logic [15:0] m_iter;

  always #5 clk = ~clk;

  pe_ctx_loop #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .init(init), .cfg_inst(cfg_inst), .run(run), .stall(stall),
    .din_N(din_n), .din_S(din_s), .din_W(din_w), .din_E(din_e),
    .dout_N(dout_n), .dout_S(dout_s), .dout_W(dout_w), .dout_E(dout_e),
    .cfg_full(cfg_full), .loop_done(loop_done), .iter_cnt(iter_cnt)
  );

  function automatic logic [23:0] mk(input logic [3:0] op, input logic [2:0] sa, input logic [2:0] sb,
                                     input logic [1:0] on, input logic [1:0] os, input logic [1:0] ow,
                                     input logic [1:0] oe, input logic we, input logic [1:0] rd,
                                     input logic [1:0] ra, input logic last);
    return {op, sa, sb, on, os, ow, oe, we, rd, ra, last};
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return $unsigned($signed(a) >>> sh);
      4'd8:  return a * b;
      4'd9:  return (a == b) ? 32'd1 : 32'd0;
      4'd10: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd11: return ($signed(a) < $signed(b)) ? a : b;
      4'd12: return ($signed(a) > $signed(b)) ? a : b;
      4'd13: return a;
      4'd14: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_src(input logic [2:0] s);
    case (s)
      3'd0: return din_n;
      3'd1: return din_s;
      3'd2: return din_w;
      3'd3: return din_e;
      3'd4: return m_res;
      3'd5: return m_rf[m_inst[2:1]];
      3'd7: return 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_out(input logic [1:0] sel);
    case (sel)
      2'd1: return m_res;
      2'd2: return m_src(m_inst[19:17]);
      2'd3: return m_rf[m_inst[2:1]];
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    int          n_lp, n_pc, wi;
    logic [23:0] n_inst, cur;
    bit          n_ev, n_ld, wr, clr;
    logic [31:0] n_res, y;
    logic [31:0] n_rf [4];
    logic [15:0] n_iter;
    n_lp = m_lp; n_pc = m_pc; n_inst = m_inst; n_ev = m_ev; n_ld = 0;
    n_res = m_res; n_rf = m_rf; n_iter = m_iter; wr = 0; wi = 0; clr = 0;
    if (rst) begin
      clr = 1; n_lp = 0; n_pc = 0; n_inst = '0; n_ev = 0; n_res = '0; n_iter = '0;
      for (int i = 0; i < 4; i++) n_rf[i] = '0;
    end else begin
      if (!stall && m_ev && m_inst[23:20] != 4'd15) begin
        y = alu_ref(m_inst[23:20], m_src(m_inst[19:17]), m_src(m_inst[16:14]));
        n_res = y;
        if (m_inst[5]) n_rf[m_inst[4:3]] = y;
      end
      if (init) begin
        if (m_lp < DEPTH) begin wr = 1; wi = m_lp; n_lp = m_lp + 1; end
        n_pc = 0; n_ev = 0;
      end else if (!stall && run && m_lp != 0) begin
        cur    = m_buf[m_pc];
        n_inst = cur;
        n_ev   = 1;
        n_ld   = cur[0] || (m_pc == m_lp - 1);
        n_pc   = n_ld ? 0 : m_pc + 1;
        n_iter = m_iter + 16'(n_ld);
      end else if (!stall) begin
        n_ev = 0;
      end
    end
    @(posedge clk);
    if (clr) for (int i = 0; i < DEPTH; i++) m_buf[i] = '0;
    if (wr) m_buf[wi] = cfg_inst;
    m_lp = n_lp; m_pc = n_pc; m_inst = n_inst; m_ev = n_ev; m_ld = n_ld;
    m_res = n_res; m_rf = n_rf; m_iter = n_iter;
    #1;
    chk("dout_N", dout_n, m_out(m_inst[13:12]));
    chk("dout_S", dout_s, m_out(m_inst[11:10]));
    chk("dout_W", dout_w, m_out(m_inst[9:8]));
    chk("dout_E", dout_e, m_out(m_inst[7:6]));
    chk("cfg_full", {31'd0, cfg_full}, {31'd0, m_lp == DEPTH});
    chk("loop_done", {31'd0, loop_done}, {31'd0, m_ld});
    chk("iter_cnt", {16'd0, iter_cnt}, {16'd0, m_iter});
    if (loop_done) ld_seen++;
  endtask

  task automatic do_reset();
    rst = 1'b1; init = 1'b0; run = 1'b0; stall = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic load(input logic [23:0] w);
    init = 1'b1; cfg_inst = w;
    step();
    init = 1'b0;
  endtask

  task automatic run_n(input int n);
    run = 1'b1;
    for (int i = 0; i < n; i++) step();
    run = 1'b0;
  endtask

  task automatic alu_case(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    do_reset();
    load(mk(op, 3'd0, 3'd2, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1));
    din_n = a; din_w = b;
    run_n(2);
    chk(name, dout_n, exp);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_buf[i] = '0;
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    m_lp = 0; m_pc = 0; m_inst = '0; m_ev = 0; m_ld = 0; m_res = '0; m_iter = '0;

    do_reset();
    chk("reset_dout_N", dout_n, 32'd0);
    chk("reset_dout_E", dout_e, 32'd0);
    chk("reset_iter", {16'd0, iter_cnt}, 32'd0);

    // single ADD context routed to N
    load(mk(4'd0, 3'd0, 3'd2, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1));
    din_n = 32'd5; din_w = 32'd7;
    run = 1'b1;
    step();
    step();
    chk("t1_add_fetch2", dout_n, 32'd12);
    step(); step(); step();
    run = 1'b0;
    chk("t1_add_stays", dout_n, 32'd12);

    // three contexts, length wrap
    do_reset();
    for (int i = 0; i < 3; i++) load(mk(4'd15, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0));
    ld_seen = 0;
    run_n(9);
    chk("t2_iter", {16'd0, iter_cnt}, 32'd3);
    chk("t2_pulses", ld_seen, 32'd3);

    // accumulator through res with rf copy
    do_reset();
    load(mk(4'd0, 3'd4, 3'd7, 2'd3, 2'd1, 2'd0, 2'd0, 1'b1, 2'd2, 2'd2, 1'b1));
    run_n(10);
    step();
    chk("t3_res", dout_s, 32'd10);
    chk("t3_rf2", dout_n, 32'd10);

    // stall mid-loop
    do_reset();
    for (int i = 0; i < 3; i++) load(mk(4'd0, 3'd4, 3'd7, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0));
    run = 1'b1;
    for (int i = 0; i < 4; i++) step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("t4_frozen_res", dout_n, 32'd3);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) step();
    run = 1'b0;
    chk("t4_iter", {16'd0, iter_cnt}, 32'd2);

    // overfill the buffer
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++)
      load(mk(4'd15, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, (i >= DEPTH) ? 1'b1 : 1'b0));
    chk("t5_full", {31'd0, cfg_full}, 32'd1);
    run_n(20);
    chk("t5_iter", {16'd0, iter_cnt}, 32'd1);

    alu_case("t6_sra", 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000);
    alu_case("t6_lts", 4'd10, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_case("t6_mul", 4'd8, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001);
    run = 1'b1; step(); step();
    rst = 1'b1; step(); rst = 1'b0; run = 1'b0;
    chk("t6_rst_dout_N", dout_n, 32'd0);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      init  = ($urandom_range(0, 9) == 0);
      run   = ($urandom_range(0, 5) != 0);
      stall = ($urandom_range(0, 6) == 0);
      cfg_inst    = 24'($urandom);
      cfg_inst[0] = ($urandom_range(0, 3) == 0);
      din_n = $urandom; din_s = $urandom; din_w = $urandom; din_e = $urandom;
      if ($urandom_range(0, 3) == 0) din_w = 32'($urandom_range(0, 40));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
